// File: rtl/carregador_instrucoes_pkg.sv
// ============================================================================
// Module : carregador_instrucoes_pkg
// Brief  : Shared widths, frame constants and loader state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package carregador_instrucoes_pkg;

    localparam int LARGURA_DADO     = 8;
    localparam int LARGURA_END      = 8;
    localparam int LARGURA_CONTAGEM = LARGURA_END + 1;

    // A TAMANHO field of zero stands for a full 256-word frame.
    localparam logic [LARGURA_DADO-1:0]     TAMANHO_CODIGO_MAXIMO = 8'h00;
    localparam logic [LARGURA_CONTAGEM-1:0] TAMANHO_MAXIMO        = 9'd256;
    localparam logic [LARGURA_DADO-1:0]     SOMA_VALIDA           = 8'h00;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECO = 3'd1,
        TAMANHO  = 3'd2,
        DADOS    = 3'd3,
        CHECKSUM = 3'd4
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/carregador_instrucoes_contador_timeout.sv
// ============================================================================
// Module : contador_timeout
// Brief  : Inter-byte idle counter with clear, enable and expiry flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic limpar_i,
    input  logic habilitar_i,
    output logic expirou_o
);

    localparam int                 LARGURA = $clog2(TIMEOUT_CICLOS);
    localparam logic [LARGURA-1:0] LIMITE  = LARGURA'(TIMEOUT_CICLOS - 1);

    logic [LARGURA-1:0] contagem_q;
    logic [LARGURA-1:0] contagem_d;

    assign expirou_o = (contagem_q == LIMITE);

    always_comb begin
        contagem_d = contagem_q;
        if (limpar_i) begin
            contagem_d = '0;
        end else if (habilitar_i && !expirou_o) begin
            contagem_d = contagem_q + LARGURA'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/carregador_instrucoes.sv
// ============================================================================
// Module : carregador_instrucoes
// Brief  : Framed byte-stream loader for the 256x8 instruction memory write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module carregador_instrucoes
    import carregador_instrucoes_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inicio_i,
    input  logic [LARGURA_DADO-1:0] byte_entrada_i,
    input  logic                    byte_valido_i,
    output logic                    byte_aceito_o,
    output logic                    wr_enable_o,
    output logic [LARGURA_END-1:0]  wr_endereco_o,
    output logic [LARGURA_DADO-1:0] wr_dado_o,
    output logic                    cpu_parado_o,
    output logic                    ocupado_o,
    output logic                    concluido_o,
    output logic                    erro_checksum_o,
    output logic                    erro_timeout_o
);

    estado_t                     estado_q, estado_d;
    logic [LARGURA_END-1:0]      ponteiro_q, ponteiro_d;
    logic [LARGURA_CONTAGEM-1:0] contagem_q, contagem_d;
    logic [LARGURA_DADO-1:0]     soma_q, soma_d;
    logic                        wr_enable_q, wr_enable_d;
    logic [LARGURA_END-1:0]      wr_endereco_q, wr_endereco_d;
    logic [LARGURA_DADO-1:0]     wr_dado_q, wr_dado_d;
    logic                        concluido_q, concluido_d;
    logic                        erro_checksum_q, erro_checksum_d;
    logic                        erro_timeout_q, erro_timeout_d;

    logic                        w_recebendo;
    logic                        w_transferencia;
    logic [LARGURA_DADO-1:0]     w_soma_mais_byte;
    logic                        w_limpar_timeout;
    logic                        w_expirou;

    // Every non-idle state is a receiving state, so readiness is a pure state decode.
    assign w_recebendo      = (estado_q != OCIOSO);
    assign w_transferencia  = w_recebendo && byte_valido_i;
    assign w_soma_mais_byte = soma_q + byte_entrada_i;

    assign byte_aceito_o   = w_recebendo;
    assign cpu_parado_o    = w_recebendo;
    assign ocupado_o       = w_recebendo;
    assign wr_enable_o     = wr_enable_q;
    assign wr_endereco_o   = wr_endereco_q;
    assign wr_dado_o       = wr_dado_q;
    assign concluido_o     = concluido_q;
    assign erro_checksum_o = erro_checksum_q;
    assign erro_timeout_o  = erro_timeout_q;

    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .limpar_i    (w_limpar_timeout),
        .habilitar_i (w_recebendo),
        .expirou_o   (w_expirou)
    );

    always_comb begin
        estado_d         = estado_q;
        ponteiro_d       = ponteiro_q;
        contagem_d       = contagem_q;
        soma_d           = soma_q;
        wr_enable_d      = 1'b0;
        wr_endereco_d    = wr_endereco_q;
        wr_dado_d        = wr_dado_q;
        concluido_d      = 1'b0;
        erro_checksum_d  = erro_checksum_q;
        erro_timeout_d   = erro_timeout_q;
        w_limpar_timeout = 1'b0;

        if (estado_q == OCIOSO) begin
            if (inicio_i) begin
                estado_d         = ENDERECO;
                erro_checksum_d  = 1'b0;
                erro_timeout_d   = 1'b0;
                soma_d           = '0;
                w_limpar_timeout = 1'b1;
            end
        end else if (w_transferencia) begin
            // A byte arriving on the expiry cycle still counts; it beats the timeout.
            w_limpar_timeout = 1'b1;
            soma_d           = w_soma_mais_byte;
            case (estado_q)
                ENDERECO: begin
                    ponteiro_d = byte_entrada_i;
                    soma_d     = byte_entrada_i;
                    estado_d   = TAMANHO;
                end
                TAMANHO: begin
                    contagem_d = (byte_entrada_i == TAMANHO_CODIGO_MAXIMO) ?
                                 TAMANHO_MAXIMO : {1'b0, byte_entrada_i};
                    estado_d   = DADOS;
                end
                DADOS: begin
                    wr_enable_d   = 1'b1;
                    wr_endereco_d = ponteiro_q;
                    wr_dado_d     = byte_entrada_i;
                    ponteiro_d    = ponteiro_q + LARGURA_END'(1);
                    contagem_d    = contagem_q - LARGURA_CONTAGEM'(1);
                    if (contagem_q == LARGURA_CONTAGEM'(1)) begin
                        estado_d = CHECKSUM;
                    end
                end
                CHECKSUM: begin
                    if (w_soma_mais_byte == SOMA_VALIDA) begin
                        concluido_d = 1'b1;
                    end else begin
                        erro_checksum_d = 1'b1;
                    end
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end else if (w_expirou) begin
            erro_timeout_d = 1'b1;
            estado_d       = OCIOSO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q        <= OCIOSO;
            ponteiro_q      <= '0;
            contagem_q      <= '0;
            soma_q          <= '0;
            wr_enable_q     <= 1'b0;
            wr_endereco_q   <= '0;
            wr_dado_q       <= '0;
            concluido_q     <= 1'b0;
            erro_checksum_q <= 1'b0;
            erro_timeout_q  <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            ponteiro_q      <= ponteiro_d;
            contagem_q      <= contagem_d;
            soma_q          <= soma_d;
            wr_enable_q     <= wr_enable_d;
            wr_endereco_q   <= wr_endereco_d;
            wr_dado_q       <= wr_dado_d;
            concluido_q     <= concluido_d;
            erro_checksum_q <= erro_checksum_d;
            erro_timeout_q  <= erro_timeout_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_carregador_instrucoes.sv
// ============================================================================
// Module : tb_carregador_instrucoes
// Brief  : Randomized self-checking bench for the instruction-memory loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_carregador_instrucoes;

    localparam int TIMEOUT_CICLOS = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inicio;
    logic [7:0] byte_entrada;
    logic       byte_valido;
    logic       byte_aceito;
    logic       wr_enable;
    logic [7:0] wr_endereco;
    logic [7:0] wr_dado;
    logic       cpu_parado;
    logic       ocupado;
    logic       concluido;
    logic       erro_checksum;
    logic       erro_timeout;

    int n_checks = 0;
    int n_erros  = 0;

    // Reference memory image and what the DUT write port actually produced.
    logic [7:0] mem_esperada [256];
    logic [7:0] mem_dut      [256];
    int         escritas_por_end [256];
    int         total_escritas  = 0;
    int         total_concluido = 0;
    logic [7:0] fila_dados [$];

    carregador_instrucoes #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inicio_i        (inicio),
        .byte_entrada_i  (byte_entrada),
        .byte_valido_i   (byte_valido),
        .byte_aceito_o   (byte_aceito),
        .wr_enable_o     (wr_enable),
        .wr_endereco_o   (wr_endereco),
        .wr_dado_o       (wr_dado),
        .cpu_parado_o    (cpu_parado),
        .ocupado_o       (ocupado),
        .concluido_o     (concluido),
        .erro_checksum_o (erro_checksum),
        .erro_timeout_o  (erro_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_enable) begin
            mem_dut[wr_endereco] = wr_dado;
            escritas_por_end[wr_endereco] = escritas_por_end[wr_endereco] + 1;
            total_escritas = total_escritas + 1;
        end
        if (concluido) begin
            total_concluido = total_concluido + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    task automatic comparar_memoria(input string tag);
        int diferencas = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_dut[i] !== mem_esperada[i]) diferencas++;
        end
        check(tag, diferencas, 0);
    endtask

    task automatic enviar_byte(input logic [7:0] b, input int espera);
        int n = 0;
        repeat (espera) @(negedge clk);
        @(negedge clk);
        byte_valido  = 1'b1;
        byte_entrada = b;
        while (!byte_aceito && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("espera_aceito", byte_aceito, 1);
        @(posedge clk);
        #1 byte_valido = 1'b0;
    endtask

    task automatic pulsar_inicio(input logic [7:0] ini, input bit valido_antes);
        @(negedge clk);
        inicio = 1'b1;
        if (valido_antes) begin
            byte_valido  = 1'b1;
            byte_entrada = ini;
            check("aceito_ocioso", byte_aceito, 0);
        end
        @(posedge clk);
        #1 inicio = 1'b0;
        @(negedge clk);
        check("cpu_parado_carga", cpu_parado, 1);
        check("ocupado_carga", ocupado, 1);
        check("erro_ck_limpo", erro_checksum, 0);
        check("erro_to_limpo", erro_timeout, 0);
        if (valido_antes) begin
            @(posedge clk);
            #1 byte_valido = 1'b0;
        end else begin
            enviar_byte(ini, 0);
        end
    endtask

    // Whole frame from fila_dados; len = fila_dados.size() in 1..256.
    task automatic carregar(input logic [7:0] ini, input bit cksum_ruim,
                            input int espera, input bit valido_antes);
        int         len         = fila_dados.size();
        int         escr_inicio = total_escritas;
        int         conc_inicio = total_concluido;
        logic [7:0] soma        = ini + 8'(len);
        logic [7:0] cks;
        for (int i = 0; i < len; i++) soma = soma + fila_dados[i];
        cks = 8'h00 - soma;
        if (cksum_ruim) cks = cks + 8'($urandom_range(1, 255));
        pulsar_inicio(ini, valido_antes);
        enviar_byte(8'(len), espera);
        for (int i = 0; i < len; i++) begin
            enviar_byte(fila_dados[i], espera);
            mem_esperada[8'(ini + 8'(i))] = fila_dados[i];
        end
        enviar_byte(cks, espera);
        @(negedge clk);
        #2;
        check("concluido_pulsos", total_concluido - conc_inicio, cksum_ruim ? 0 : 1);
        check("erro_checksum", erro_checksum, cksum_ruim);
        check("erro_timeout", erro_timeout, 0);
        check("ocupado_fim", ocupado, 0);
        check("cpu_parado_fim", cpu_parado, 0);
        check("escritas_quadro", total_escritas - escr_inicio, len);
        comparar_memoria("memoria");
    endtask

    task automatic preencher_fixo(input logic [31:0] palavra, input int n);
        fila_dados.delete();
        for (int i = 0; i < n; i++) fila_dados.push_back(palavra[8*(n-1-i) +: 8]);
    endtask

    task automatic preencher_aleatorio(input int n);
        fila_dados.delete();
        for (int i = 0; i < n; i++) fila_dados.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        rst_n        = 1'b0;
        inicio       = 1'b0;
        byte_valido  = 1'b0;
        byte_entrada = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem_esperada[i]     = 8'h00;
            mem_dut[i]          = 8'h00;
            escritas_por_end[i] = 0;
        end
        #12;
        check("reset_saidas", {byte_aceito, wr_enable, wr_endereco, wr_dado, cpu_parado,
                               ocupado, concluido, erro_checksum, erro_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        preencher_fixo(32'h00A1B2C3, 3);
        carregar(8'h10, 1'b0, 0, 1'b0);
        preencher_fixo(32'h01020304, 4);
        carregar(8'hFE, 1'b0, 1, 1'b0);
        preencher_fixo(32'h00A1B2C3, 3);
        carregar(8'h10, 1'b1, 0, 1'b0);

        // Stall after TAMANHO until the idle limit aborts the frame.
        pulsar_inicio(8'h40, 1'b0);
        enviar_byte(8'h02, 0);
        repeat (1100) @(negedge clk);
        #2;
        check("timeout_flag", erro_timeout, 1);
        check("timeout_ocupado", ocupado, 0);
        check("timeout_cpu", cpu_parado, 0);
        check("timeout_aceito", byte_aceito, 0);
        preencher_aleatorio(2);
        carregar(8'h40, 1'b0, TIMEOUT_CICLOS - 2, 1'b0);

        // Asynchronous reset in the middle of the data phase.
        preencher_aleatorio(2);
        pulsar_inicio(8'h80, 1'b0);
        enviar_byte(8'h05, 0);
        for (int i = 0; i < 2; i++) begin
            enviar_byte(fila_dados[i], 0);
            mem_esperada[8'h80 + i] = fila_dados[i];
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", {byte_aceito, wr_enable, wr_endereco, wr_dado, cpu_parado,
                              ocupado, concluido, erro_checksum, erro_timeout}, 0);
        comparar_memoria("memoria_pos_reset");
        @(negedge clk);
        rst_n = 1'b1;
        preencher_aleatorio(5);
        carregar(8'h80, 1'b0, 0, 1'b0);

        // Full 256-byte frame with the start byte offered alongside Inicio.
        for (int i = 0; i < 256; i++) escritas_por_end[i] = 0;
        preencher_aleatorio(256);
        carregar(8'($urandom_range(0, 255)), 1'b0, 0, 1'b1);
        begin
            int erradas = 0;
            for (int i = 0; i < 256; i++) if (escritas_por_end[i] != 1) erradas++;
            check("escrita_unica_256", erradas, 0);
        end

        for (int k = 0; k < 8; k++) begin
            preencher_aleatorio($urandom_range(1, 24));
            carregar(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
        $finish;
    end

endmodule

`default_nettype wire
